mod_sub_vec: RTL and testbench

//  Lane-serial vector modular subtractor: res[k] = (op0[k] - op1[k]) mod q for every lane k.

---
 rtl/pq_alu_pkg.sv | 10 +
 rtl/mod_sub.sv | 28 ++
 rtl/mod_sub_vec.sv | 90 +++++++++
 tb/tb_mod_sub_vec.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pq_alu_pkg.sv
// Shared types and default sizing for the PQ_ALU datapath blocks.
// Holds the modular-subtractor FSM state encoding.
package pq_alu_pkg;

   typedef enum logic [1:0] {SUB_IDLE, SUB_BUSY, SUB_DONE} sub_state_e;

   localparam int PQ_LANES_DEFAULT      = 8;
   localparam int PQ_DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/mod_sub.sv
// Combinational single-lane modular subtractor (a - b) mod q.
// Define PQ_SUB_LAZY_RED_EN for lazy reduction: res = a - b + q, range [0,2q).
module mod_sub
   import pq_alu_pkg::*;
#(
   parameter int DATA_WIDTH = PQ_DATA_WIDTH_DEFAULT
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] q,
   output logic [DATA_WIDTH-1:0] res
);

`ifdef PQ_SUB_LAZY_RED_EN
   // Caller keeps q below 2^(DATA_WIDTH-1), so a - b + q never wraps.
   always_comb res = a - b + q;
`else
   logic [DATA_WIDTH-1:0] diff;
   logic                  borrow;

   always_comb begin
      diff   = a - b;
      borrow = (a < b);
      res    = borrow ? diff + q : diff;
   end
`endif

endmodule

// File: rtl/mod_sub_vec.sv
// Lane-serial vector modular subtractor: one shared mod_sub walks all LANES per vector.
// Honours PQ_SUB_LAZY_RED_EN through the mod_sub instance; handshake is identical in both builds.
module mod_sub_vec
   import pq_alu_pkg::*;
#(
   parameter int DATA_WIDTH = PQ_DATA_WIDTH_DEFAULT,
   parameter int LANES      = PQ_LANES_DEFAULT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [LANES*DATA_WIDTH-1:0] op0_i,
   input  logic [LANES*DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0]       q_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [LANES*DATA_WIDTH-1:0] res_o
);

   localparam int            VW   = LANES * DATA_WIDTH;
   localparam int            CW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   sub_state_e            state, state_nxt;
   logic [VW-1:0]         op0_r, op1_r, res_r;
   logic [DATA_WIDTH-1:0] q_r, lane_a, lane_b, lane_res;
   logic [CW-1:0]         cnt;
   logic                  accept, last_lane;
   int                    lane_base;

   assign accept    = valid_i && ready_o;
   assign last_lane = (cnt == LAST);
   assign lane_base = int'(cnt) * DATA_WIDTH;
   assign lane_a    = op0_r[lane_base +: DATA_WIDTH];
   assign lane_b    = op1_r[lane_base +: DATA_WIDTH];
   assign res_o     = res_r;

   mod_sub #(.DATA_WIDTH(DATA_WIDTH)) u_mod_sub (
      .a   (lane_a),
      .b   (lane_b),
      .q   (q_r),
      .res (lane_res)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= SUB_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         SUB_IDLE: if (accept)    state_nxt = SUB_BUSY;
         SUB_BUSY: if (last_lane) state_nxt = SUB_DONE;
         SUB_DONE: if (ready_i)   state_nxt = SUB_IDLE;
         default:                 state_nxt = SUB_IDLE;
      endcase
   end

   always_comb begin
      ready_o = (state == SUB_IDLE);
      valid_o = (state == SUB_DONE);
   end

   // NOTE: operand registers skip reset; they are always loaded on accept before BUSY reads them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op0_r <= op0_i;
         op1_r <= op1_i;
         q_r   <= q_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_r <= '0;
         cnt   <= '0;
      end else if (accept) begin
         res_r <= '0;
         cnt   <= '0;
      end else if (state == SUB_BUSY) begin
         res_r[lane_base +: DATA_WIDTH] <= lane_res;
         cnt                            <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_mod_sub_vec.sv
// Self-checking bench for mod_sub_vec: directed lane table, backpressure, mid-op reset, random vectors.
// Expected values follow PQ_SUB_LAZY_RED_EN when the bench is built with that macro.
module tb_mod_sub_vec;

   localparam int DW = 32;
   localparam int LN = 8;
   localparam int VW = DW * LN;

   typedef logic [DW-1:0] word_t;
   typedef logic [VW-1:0] vec_t;

`ifdef PQ_SUB_LAZY_RED_EN
   localparam bit LAZY = 1'b1;
`else
   localparam bit LAZY = 1'b0;
`endif

   logic  clk_i = 1'b0;
   logic  rst_i = 1'b1;
   logic  valid_i, ready_o, valid_o, ready_i;
   vec_t  op0_i, op1_i, res_o;
   word_t q_i;

   int checks   = 0;
   int failures = 0;

   mod_sub_vec #(.DATA_WIDTH(DW), .LANES(LN)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .op0_i   (op0_i),
      .op1_i   (op1_i),
      .q_i     (q_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .res_o   (res_o)
   );

   always #5 clk_i = ~clk_i;

   assert property (@(posedge clk_i) disable iff (rst_i)
                    (valid_o && !ready_i) |=> ($stable(res_o) && valid_o))
      else begin
         failures++;
         $display("FAIL hold_assert: res_o/valid_o changed under backpressure at t=%0t", $time);
      end

   task automatic check(input string name, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: mathematical (a - b) mod q, or a - b + q when lazily reduced.
   function automatic word_t model_lane(input word_t a, input word_t b, input word_t q);
      longint unsigned la, lb, lq, r;
      la = a; lb = b; lq = q;
      if (LAZY) r = (la + lq - lb) & 64'hFFFF_FFFF;
      else      r = (la + lq - lb) % lq;
      return word_t'(r);
   endfunction

   function automatic vec_t model_vec(input vec_t a, input vec_t b, input word_t q);
      vec_t r;
      for (int k = 0; k < LN; k++) r[k*DW +: DW] = model_lane(a[k*DW +: DW], b[k*DW +: DW], q);
      return r;
   endfunction

   function automatic vec_t rand_vec(input word_t q);
      vec_t v;
      for (int k = 0; k < LN; k++) v[k*DW +: DW] = $urandom() % q;
      return v;
   endfunction

   task automatic send(input vec_t a, input vec_t b, input word_t q);
      int n = 0;
      while (!ready_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, n);
      end
      op0_i = a; op1_i = b; q_i = q; valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      op0_i   = rand_vec(32'hFFFF_FFFF);
      op1_i   = rand_vec(32'hFFFF_FFFF);
      q_i     = $urandom();
   endtask

   // Called at the negedge right after the accept edge; lat counts edges since accept.
   task automatic wait_result(output vec_t r, output int lat);
      lat = 0;
      while (!valid_o && lat < 40) begin
         @(negedge clk_i);
         lat++;
      end
      if (!valid_o) begin
         checks++;
         failures++;
         $display("FAIL result_timeout: valid_o=%0b after %0d cycles, required 1", valid_o, lat);
      end
      r = res_o;
   endtask

   typedef struct {
      string name;
      word_t q;
      word_t ae, be, ee;
      word_t ao, bo, eo;
   } row_t;

   row_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  a, b, e, r, held;
      word_t q;
      int    lat, stall;

      tbl[0] = '{"all_5_3",    3329,    5, 3, LAZY ? 3331 : 2,
                                        5, 3, LAZY ? 3331 : 2};
      tbl[1] = '{"alt_wrap",   3329,    3, 5, 3327,
                                        0, 3328, 1};
      tbl[2] = '{"equal_max",  3329,    3328, 3328, LAZY ? 3329 : 0,
                                        3328, 3328, LAZY ? 3329 : 0};
      tbl[3] = '{"dilithium",  8380417, 1, 8380416, 2,
                                        8380416, 0, LAZY ? 16760833 : 8380416};
      tbl[4] = '{"q_one",      1,       0, 0, LAZY ? 1 : 0,
                                        0, 0, LAZY ? 1 : 0};
      tbl[5] = '{"zero_zero",  3329,    0, 0, LAZY ? 3329 : 0,
                                        0, 0, LAZY ? 3329 : 0};

      valid_i = 1'b0; ready_i = 1'b1;
      op0_i = '0; op1_i = '0; q_i = '0;
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("reset_ready_o", ready_o, 1);
      check("reset_valid_o", valid_o, 0);
      check("reset_res_o", res_o, '0);
      rst_i = 1'b0;

      // Directed lane table: even/odd lane patterns with constant expectations.
      foreach (tbl[i]) begin
         for (int k = 0; k < LN; k++) begin
            a[k*DW +: DW] = (k % 2 == 0) ? tbl[i].ae : tbl[i].ao;
            b[k*DW +: DW] = (k % 2 == 0) ? tbl[i].be : tbl[i].bo;
            e[k*DW +: DW] = (k % 2 == 0) ? tbl[i].ee : tbl[i].eo;
         end
         send(a, b, tbl[i].q);
         wait_result(r, lat);
         check({tbl[i].name, "_res"}, r, e);
         check({tbl[i].name, "_latency"}, vec_t'(lat), vec_t'(LN));
         @(negedge clk_i);
         check({tbl[i].name, "_ready_after"}, {valid_o, ready_o}, 2'b01);
      end

      // Backpressure in DONE: output held, valid_i ignored, ready_o one cycle after release.
      q = 3329;
      a = rand_vec(q); b = rand_vec(q); e = model_vec(a, b, q);
      ready_i = 1'b0;
      send(a, b, q);
      wait_result(held, lat);
      check("bp_res", held, e);
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         op0_i   = rand_vec(q);
         op1_i   = rand_vec(q);
         @(negedge clk_i);
         check("bp_hold_valid_o", valid_o, 1);
         check("bp_hold_res_o", res_o, held);
         check("bp_hold_ready_o", ready_o, 0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_release", {valid_o, ready_o}, 2'b01);
      repeat (2) @(negedge clk_i);
      check("bp_no_phantom", {valid_o, ready_o}, 2'b01);

      // Reset while the lane counter sits at 3 in BUSY.
      for (int k = 0; k < LN; k++) begin
         a[k*DW +: DW] = 100 + k;
         b[k*DW +: DW] = 7;
      end
      send(a, b, q);
      repeat (3) @(negedge clk_i);
      check("midrst_partial_res", res_o == '0, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("midrst_valid_o", valid_o, 0);
      check("midrst_res_o", res_o, '0);
      check("midrst_ready_o", ready_o, 1);
      a = rand_vec(q); b = rand_vec(q); e = model_vec(a, b, q);
      send(a, b, q);
      wait_result(r, lat);
      check("midrst_next_res", r, e);
      check("midrst_next_latency", vec_t'(lat), vec_t'(LN));
      @(negedge clk_i);

      // Back-to-back random vectors with occasional downstream stalls.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       q = 3329;
            1:       q = 8380417;
            2:       q = $urandom_range(1, 255);
            default: q = $urandom_range(1, 32'h7FFF_FFFF);
         endcase
         a = rand_vec(q); b = rand_vec(q); e = model_vec(a, b, q);
         stall = $urandom_range(0, 2);
         ready_i = (stall == 0);
         send(a, b, q);
         wait_result(r, lat);
         check("rand_res", r, e);
         check("rand_latency", vec_t'(lat), vec_t'(LN));
         repeat (stall) @(negedge clk_i);
         check("rand_res_held", res_o, e);
         ready_i = 1'b1;
         @(negedge clk_i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
